// File: rtl/e155_pkg.sv
// Shared types, segment table and keypad map for the E155 hex entry/display core.
package e155_pkg;

  typedef enum logic {SCAN = 1'b0, HELD = 1'b1} kp_state_t;

  typedef struct packed {
    logic      sel;
    kp_state_t fsm;
    logic [3:0] col;
    logic [3:0] digit1;
    logic [3:0] digit2;
  } core_state_t;

  localparam core_state_t RESET_STATE = '{
    sel: 1'b0, fsm: SCAN, col: 4'b0001, digit1: 4'h0, digit2: 4'h0
  };

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [1:0] row_index(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return 4'hC;
      4'b11_00: return 4'hE;
      4'b11_01: return 4'h0;
      4'b11_10: return 4'hF;
      4'b11_11: return 4'hD;
      default:  return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/e155_asic_seven_seg_decoder.sv
// Hex to active-low seven-segment decode.
module seven_seg_decoder
  import e155_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/e155_asic.sv
// E155 two-digit hex entry/display core: switch display or keypad scan with two-key history.
module e155_asic
  import e155_pkg::*;
(
  input  logic       ph1,
  input  logic       ph2,
  input  logic       reset,
  input  logic       mode,
  input  logic       pulldownEn,
  input  logic [3:0] switch1,
  input  logic [3:0] switch2,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [6:0] seg,
  output logic       multi1,
  output logic       multi2
);

  core_state_t cur, master, nxt;
  logic [3:0]  r;
  logic [3:0]  disp_hex;

  assign r = rows & {4{pulldownEn}};

  // Next-state: sel toggle, keypad scan/held FSM and display shift.
  always_comb begin
    nxt     = cur;
    nxt.sel = ~cur.sel;
    if (!reset) begin
      nxt = RESET_STATE;
    end else if (mode) begin
      case (cur.fsm)
        SCAN: begin
          if (r == 4'b0000) begin
            nxt.col = {cur.col[2:0], cur.col[3]};
          end else begin
            nxt.digit2 = cur.digit1;
            nxt.digit1 = key_map(row_index(r), col_index(cur.col));
            nxt.fsm    = HELD;
          end
        end
        HELD: begin
          if (r == 4'b0000) nxt.fsm = SCAN;
          else              nxt.fsm = HELD;
        end
        default: nxt.fsm = SCAN;
      endcase
    end else begin
      // Switch mode freezes the keypad state where it is.
      nxt.fsm = cur.fsm;
    end
  end

  // Master latch, transparent during ph2.
  always_latch begin
    if (ph2) master <= nxt;
  end

  // Slave stage, updated on rising ph1.
  always_ff @(posedge ph1) begin
    cur <= master;
  end

  assign multi1  = ~cur.sel;
  assign multi2  = cur.sel;
  assign columns = mode ? cur.col : 4'b0000;

  always_comb begin
    if (mode) disp_hex = multi1 ? cur.digit1 : cur.digit2;
    else      disp_hex = multi1 ? switch1 : switch2;
  end

  seven_seg_decoder u_dec (
    .hex (disp_hex),
    .seg (seg)
  );

endmodule

// File: tb/tb_e155_asic.sv
// Directed self-checking bench for e155_asic.
module tb_e155_asic;

  logic       ph1, ph2, reset, mode, pulldownEn;
  logic [3:0] switch1, switch2, rows, columns;
  logic [6:0] seg;
  logic       multi1, multi2;

  int checks   = 0;
  int failures = 0;
  logic exp_sel = 1'b0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;

  e155_asic dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .mode(mode), .pulldownEn(pulldownEn),
    .switch1(switch1), .switch2(switch2), .rows(rows),
    .columns(columns), .seg(seg), .multi1(multi1), .multi2(multi2)
  );

  // Two-phase non-overlapping clock, 20-unit period.
  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    forever begin
      #2 ph1 = 1'b1;
      #8 ph1 = 1'b0;
      #2 ph2 = 1'b1;
      #6 ph2 = 1'b0;
      #2;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample point is 3 units after rising ph1.
  task automatic tick();
    @(posedge ph1);
    if (!reset) exp_sel = 1'b0;
    else        exp_sel = ~exp_sel;
    #3;
  endtask

  task automatic check_disp(input string tag, input logic [6:0] d1, input logic [6:0] d2);
    check_value({tag, "_multi1"}, {31'd0, multi1}, {31'd0, ~exp_sel});
    check_value({tag, "_multi2"}, {31'd0, multi2}, {31'd0, exp_sel});
    check_value({tag, "_seg"}, {25'd0, seg}, {25'd0, (exp_sel ? d2 : d1)});
  endtask

  task automatic check_cols(input string tag, input logic [3:0] c);
    check_value({tag, "_columns"}, {28'd0, columns}, {28'd0, c});
  endtask

  logic [3:0] scan_seq [0:3];

  initial begin
    reset = 1'b0; mode = 1'b0; pulldownEn = 1'b1;
    switch1 = 4'h1; switch2 = 4'h8; rows = 4'b0000;
    scan_seq[0] = 4'b0010; scan_seq[1] = 4'b0100;
    scan_seq[2] = 4'b1000; scan_seq[3] = 4'b0001;

    tick(); tick();
    check_disp("reset_sw", S1, S8);
    check_value("reset_multi1_const", {31'd0, multi1}, 32'd1);
    check_cols("reset_sw", 4'b0000);
    reset = 1'b1;

    // Switch mode alternation.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_disp("sw_alt", S1, S8);
      check_cols("sw_alt", 4'b0000);
    end

    // Keypad mode scan with no key.
    mode = 1'b1;
    #1;
    check_cols("kp_start", 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_cols("kp_scan", scan_seq[i]);
      check_disp("kp_scan", S0, S0);
    end
    tick(); tick(); tick();
    check_cols("kp_pre_a", 4'b1000);

    // Press row0 on column 3 -> A.
    rows = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cols("kp_held_a", 4'b1000);
      check_disp("kp_held_a", SA, S0);
    end
    rows = 4'b0000;
    tick();
    check_cols("kp_release_a", 4'b1000);
    tick(); tick(); tick();
    check_cols("kp_pre_f", 4'b0100);

    // Press row3 on column 2 -> F, A shifts to digit 2.
    rows = 4'b1000;
    tick();
    check_cols("kp_held_f", 4'b0100);
    check_disp("kp_held_f", SF, SA);
    tick();
    check_disp("kp_held_f2", SF, SA);
    rows = 4'b0000;
    tick();
    check_cols("kp_release_f", 4'b0100);
    tick();
    check_cols("kp_resume", 4'b1000);

    // Pull-downs disabled: rows ignored.
    pulldownEn = 1'b0;
    rows = 4'b1111;
    tick();
    check_cols("pd_off", 4'b0001);
    check_disp("pd_off", SF, SA);
    tick();
    check_cols("pd_off2", 4'b0010);
    check_disp("pd_off2", SF, SA);

    // Multiple rows, lowest wins: row0 on column 1 -> 2.
    pulldownEn = 1'b1;
    tick();
    check_cols("multi_row", 4'b0010);
    check_disp("multi_row", S2, SF);

    // Reset while HELD.
    reset = 1'b0;
    tick();
    check_cols("reset_held", 4'b0001);
    check_disp("reset_held", S0, S0);
    reset = 1'b1;
    rows = 4'b0000;
    tick();
    check_disp("after_reset", S0, S0);
    check_cols("after_reset", 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
